// File: rtl/m004_serial_ripple_subtractor.sv
// Bit-serial ripple-borrow subtractor: computes a - b - bin one bit per clock,
// LSB first, with valid/ready handshakes on the operand and result sides.
module m004_serial_ripple_subtractor #(
   parameter int width = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [width-1:0] a_i,
   input  logic [width-1:0] b_i,
   input  logic             bin_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [width-1:0] diff_o,
   output logic             bout_o,
   output logic             ovf_o
);

   localparam int CW = (width > 1) ? $clog2(width) : 1;
   localparam logic [CW-1:0] LAST = CW'(width - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [width-1:0] a_q, a_d;
   logic [width-1:0] b_q, b_d;
   logic [width-1:0] res_q, res_d;
   logic [width-1:0] diff_q, diff_d;
   logic             br_q, br_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;

   logic             bit_a, bit_b, bit_d, br_next;

   // Single full-subtractor stage acting on the bit selected by the counter.
   always_comb begin
      bit_a   = a_q[cnt_q];
      bit_b   = b_q[cnt_q];
      bit_d   = bit_a ^ bit_b ^ br_q;
      br_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      diff_d  = diff_q;
      br_d    = br_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (valid_i) begin
               a_d     = a_i;
               b_d     = b_i;
               br_d    = bin_i;
               cnt_d   = '0;
               res_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            res_d[cnt_q] = bit_d;
            br_d         = br_next;
            cnt_d        = cnt_q + CW'(1);
            // Publish only on the final bit so a partial result is never visible.
            if (cnt_q == LAST) begin
               diff_d  = res_d;
               bout_d  = br_next;
               ovf_d   = (a_q[width-1] != b_q[width-1]) && (bit_d != a_q[width-1]);
               state_d = DONE;
            end
         end
         DONE: begin
            if (ready_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         diff_q  <= '0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         diff_q  <= diff_d;
         br_q    <= br_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign ready_o = (state_q == IDLE);
   assign valid_o = (state_q == DONE);
   assign diff_o  = diff_q;
   assign bout_o  = bout_q;
   assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_m004_serial_ripple_subtractor.sv
// Bench for the serial subtractor: width-4 and width-8 instances checked every
// cycle against an arithmetic timeline model, plus directed literal checks.
module tb_m004_serial_ripple_subtractor;

   localparam int PH_IDLE = 0;
   localparam int PH_RUN  = 1;
   localparam int PH_DONE = 2;

   typedef struct packed {
      logic [7:0] diff;
      logic       bout;
      logic       ovf;
   } res_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid_in [2];
   logic [7:0] a_in     [2];
   logic [7:0] b_in     [2];
   logic       bin_in   [2];
   logic       ready_in [2];
   logic       ready_out[2];
   logic       valid_out[2];
   logic [7:0] diff_out [2];
   logic       bout_out [2];
   logic       ovf_out  [2];
   logic [3:0] diff4;
   logic [7:0] diff8;

   int   passCount = 0;
   int   totalCount = 0;
   bit   checking = 1'b0;

   int   m_phase[2] = '{PH_IDLE, PH_IDLE};
   int   m_timer[2] = '{0, 0};
   res_t m_pend [2] = '{'0, '0};
   res_t m_out  [2] = '{'0, '0};

   always #5 clk = ~clk;

   m004_serial_ripple_subtractor #(.width(4)) dut4 (
      .clk_i  (clk),
      .rst_i  (rst),
      .valid_i(valid_in[0]),
      .ready_o(ready_out[0]),
      .a_i    (a_in[0][3:0]),
      .b_i    (b_in[0][3:0]),
      .bin_i  (bin_in[0]),
      .valid_o(valid_out[0]),
      .ready_i(ready_in[0]),
      .diff_o (diff4),
      .bout_o (bout_out[0]),
      .ovf_o  (ovf_out[0])
   );

   m004_serial_ripple_subtractor #(.width(8)) dut8 (
      .clk_i  (clk),
      .rst_i  (rst),
      .valid_i(valid_in[1]),
      .ready_o(ready_out[1]),
      .a_i    (a_in[1]),
      .b_i    (b_in[1]),
      .bin_i  (bin_in[1]),
      .valid_o(valid_out[1]),
      .ready_i(ready_in[1]),
      .diff_o (diff8),
      .bout_o (bout_out[1]),
      .ovf_o  (ovf_out[1])
   );

   assign diff_out[0] = {4'b0000, diff4};
   assign diff_out[1] = diff8;

   function automatic int wOf(int k);
      return (k == 0) ? 4 : 8;
   endfunction

   // Reference result from plain integer arithmetic, unsigned and signed views.
   function automatic res_t refSub(int w, logic [7:0] a, logic [7:0] b, logic bin);
      res_t r;
      int full = 1 << w;
      int ua = int'(a) % full;
      int ub = int'(b) % full;
      int u  = ua - ub - int'(bin);
      int sa = (ua >= full / 2) ? ua - full : ua;
      int sb = (ub >= full / 2) ? ub - full : ub;
      int s  = sa - sb - int'(bin);
      r.diff = 8'((u + full) % full);
      r.bout = (u < 0);
      r.ovf  = (s >= full / 2) || (s < -(full / 2));
      return r;
   endfunction

   // Timeline model: accept in idle, result appears width edges later, held until taken.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            m_phase[k] <= PH_IDLE;
            m_timer[k] <= 0;
            m_out[k]   <= '0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            case (m_phase[k])
               PH_IDLE: if (valid_in[k]) begin
                  m_pend[k]  <= refSub(wOf(k), a_in[k], b_in[k], bin_in[k]);
                  m_timer[k] <= wOf(k);
                  m_phase[k] <= PH_RUN;
               end
               PH_RUN: begin
                  m_timer[k] <= m_timer[k] - 1;
                  if (m_timer[k] == 1) begin
                     m_out[k]   <= m_pend[k];
                     m_phase[k] <= PH_DONE;
                  end
               end
               default: if (ready_in[k]) m_phase[k] <= PH_IDLE;
            endcase
         end
      end
   end

   task automatic checkOutput(string name, logic [7:0] act, logic [7:0] exp);
      totalCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (checking) begin
         for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("ready_w%0d", wOf(k)), 8'(ready_out[k]), 8'(m_phase[k] == PH_IDLE));
            checkOutput($sformatf("valid_w%0d", wOf(k)), 8'(valid_out[k]), 8'(m_phase[k] == PH_DONE));
            checkOutput($sformatf("diff_w%0d", wOf(k)), diff_out[k], m_out[k].diff);
            checkOutput($sformatf("bout_w%0d", wOf(k)), 8'(bout_out[k]), 8'(m_out[k].bout));
            checkOutput($sformatf("ovf_w%0d", wOf(k)), 8'(ovf_out[k]), 8'(m_out[k].ovf));
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(int k, logic [7:0] a, logic [7:0] b, logic bin);
      valid_in[k] = 1'b1;
      a_in[k]     = a;
      b_in[k]     = b;
      bin_in[k]   = bin;
      tick();
      valid_in[k] = 1'b0;
      a_in[k]     = ~a;
      b_in[k]     = ~b;
      bin_in[k]   = ~bin;
   endtask

   task automatic waitResult(int k, output int edges);
      edges = 0;
      while (!valid_out[k] && edges < 50) begin
         tick();
         edges++;
      end
      checkOutput("valid_seen", 8'(valid_out[k]), 8'd1);
   endtask

   task automatic checkResult(int k, string tag, logic [7:0] d, logic bo, logic ov);
      checkOutput({tag, "_diff"}, diff_out[k], d);
      checkOutput({tag, "_bout"}, 8'(bout_out[k]), 8'(bo));
      checkOutput({tag, "_ovf"}, 8'(ovf_out[k]), 8'(ov));
   endtask

   task automatic consume(int k);
      ready_in[k] = 1'b1;
      tick();
      ready_in[k] = 1'b0;
      checkOutput("ready_after_take", 8'(ready_out[k]), 8'd1);
      checkOutput("valid_after_take", 8'(valid_out[k]), 8'd0);
   endtask

   initial begin
      int edges;
      int waited;
      res_t r;
      for (int k = 0; k < 2; k++) begin
         valid_in[k] = 1'b0;
         a_in[k]     = '0;
         b_in[k]     = '0;
         bin_in[k]   = 1'b0;
         ready_in[k] = 1'b0;
      end
      tick();
      tick();
      for (int k = 0; k < 2; k++) begin
         checkOutput("reset_ready", 8'(ready_out[k]), 8'd1);
         checkOutput("reset_valid", 8'(valid_out[k]), 8'd0);
         checkResult(k, "reset", 8'h00, 1'b0, 1'b0);
      end
      rst = 1'b0;
      checking = 1'b1;
      tick();

      // 9 - 3: -7 - 3 = -10 overflows the 4-bit signed range.
      applyStimulus(0, 8'h9, 8'h3, 1'b0);
      waitResult(0, edges);
      checkOutput("latency_w4", 8'(edges), 8'd4);
      checkResult(0, "t1", 8'h6, 1'b0, 1'b1);
      consume(0);

      applyStimulus(0, 8'h3, 8'h5, 1'b0);
      waitResult(0, edges);
      checkResult(0, "t2a", 8'hE, 1'b1, 1'b0);
      consume(0);
      applyStimulus(0, 8'h0, 8'h0, 1'b1);
      waitResult(0, edges);
      checkResult(0, "t2b", 8'hF, 1'b1, 1'b0);
      consume(0);

      applyStimulus(0, 8'h8, 8'h1, 1'b0);
      waitResult(0, edges);
      checkResult(0, "t3a", 8'h7, 1'b0, 1'b1);
      consume(0);
      applyStimulus(0, 8'h7, 8'hF, 1'b0);
      waitResult(0, edges);
      checkResult(0, "t3b", 8'h8, 1'b1, 1'b1);
      consume(0);

      // Backpressure with new operands offered throughout RUN and DONE.
      applyStimulus(0, 8'h9, 8'h3, 1'b0);
      valid_in[0] = 1'b1;
      a_in[0]     = 8'h2;
      b_in[0]     = 8'h1;
      checkOutput("t4_ready_run", 8'(ready_out[0]), 8'd0);
      waitResult(0, edges);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("t4_hold_valid", 8'(valid_out[0]), 8'd1);
         checkOutput("t4_hold_ready", 8'(ready_out[0]), 8'd0);
         checkOutput("t4_hold_diff", diff_out[0], 8'h6);
      end
      valid_in[0] = 1'b0;
      consume(0);
      checkOutput("t4_keep_diff", diff_out[0], 8'h6);

      // Asynchronous reset mid-RUN.
      applyStimulus(0, 8'h9, 8'h3, 1'b0);
      tick();
      tick();
      #2;
      rst = 1'b1;
      #1;
      checkOutput("t5_ready", 8'(ready_out[0]), 8'd1);
      checkOutput("t5_valid", 8'(valid_out[0]), 8'd0);
      checkOutput("t5_diff", diff_out[0], 8'h0);
      tick();
      rst = 1'b0;
      applyStimulus(0, 8'h5, 8'h2, 1'b0);
      waitResult(0, edges);
      checkOutput("t5_latency", 8'(edges), 8'd4);
      checkResult(0, "t5", 8'h3, 1'b0, 1'b0);
      consume(0);

      applyStimulus(1, 8'h00, 8'h01, 1'b0);
      waitResult(1, edges);
      checkOutput("latency_w8", 8'(edges), 8'd8);
      checkResult(1, "t6", 8'hFF, 1'b1, 1'b0);
      consume(1);

      // Pin the reference function against a few hand-worked results.
      r = refSub(8, 8'h80, 8'h01, 1'b0);
      checkOutput("ref_80_01", {r.diff[7:1], r.ovf}, {7'h3F, 1'b1});
      r = refSub(8, 8'h10, 8'h0F, 1'b1);
      checkOutput("ref_10_0F", {r.diff[7:1], r.bout}, {7'h00, 1'b0});

      for (int op = 0; op < 1000; op++) begin
         applyStimulus(1, 8'($urandom), 8'($urandom), 1'($urandom));
         waited = 0;
         do begin
            ready_in[1] = 1'($urandom_range(0, 1));
            tick();
            waited++;
         end while (m_phase[1] != PH_IDLE && waited < 100);
         ready_in[1] = 1'b0;
         checkOutput("rand_drain", 8'(ready_out[1]), 8'd1);
      end

      tick();
      checking = 1'b0;
      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
